// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, reset vector, fetch FSM state
// encoding and logic-level constants used across the fetch datapath.
package cpu_pkg;

    localparam int DEFAULT_ADDR_W  = 15;
    localparam int DEFAULT_INSTR_W = 16;

    localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_RESET_VEC = '0;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } pc_fetch_state_e;

endpackage : cpu_pkg

// File: rtl/pc_reg.sv
// Program counter register. On enable, loads the jump target (load has
// priority) or increments with natural wraparound at 2^ADDR_W; otherwise holds.
module pc_reg #(
    parameter int                ADDR_W    = cpu_pkg::DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    // PC update: load beats increment; the adder drops its carry so the
    // top address rolls over to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is assigned with <= so every flop samples pre-edge values.
        if (!rst_n) begin
            q <= RESET_VEC;
        end else if (en) begin
            if (load) begin
                q <= d;
            end else if (inc) begin
                q <= q + ADDR_W'(1);
            end
        end
    end

endmodule : pc_reg

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage. Fetches one instruction at a
// time over imem req/ack, then holds it for execute over valid/ready. The PC
// advances only on the issue handshake, using the jump controller's decision.
// Optional build macro PC_PERF_CNT_EN adds a saturating taken-jump counter.
module pc_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = DEFAULT_ADDR_W,
    parameter int                INSTR_W   = DEFAULT_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEFAULT_RESET_VEC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_load,
    input  logic               pc_inc,
    input  logic [ADDR_W-1:0]  a_val,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
`ifdef PC_PERF_CNT_EN
    ,
    output logic [15:0]        taken_cnt
`endif
);

    pc_fetch_state_e   state;
    logic              req_q;
    logic [ADDR_W-1:0] pc;
    logic              fetch_done;
    logic              issue_hs;

    // req_q is only ever high in FETCH, so an ack in any other cycle
    // (including the first cycle after reset) is ignored.
    assign fetch_done = req_q && imem_ack;
    assign issue_hs   = (state == ISSUE) && instr_ready;

    // All outputs come straight from flops: no ack/ready combinational path.
    assign imem_req    = req_q;
    assign imem_addr   = pc;
    assign instr_valid = (state == ISSUE);

    pc_reg #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (RESET_VEC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (issue_hs),
        .load  (pc_load),
        .inc   (pc_inc),
        .d     (a_val),
        .q     (pc)
    );

    // Fetch/issue sequencing; the request flop is raised for the cycle after
    // entering FETCH and dropped together with the move to ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            req_q <= LOW;
        end else begin
            case (state)
                FETCH: begin
                    if (fetch_done) begin
                        state <= ISSUE;
                        req_q <= LOW;
                    end else begin
                        req_q <= HIGH;
                    end
                end
                ISSUE: begin
                    if (instr_ready) begin
                        state <= FETCH;
                        req_q <= HIGH;
                    end
                end
                default: begin
                    state <= FETCH;
                    req_q <= LOW;
                end
            endcase
        end
    end

    // Capture the returned word and its address; held through the issue stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= '0;
            instr_pc <= RESET_VEC;
        end else if (fetch_done) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
        end
    end

`ifdef PC_PERF_CNT_EN
    // Count retired instructions that redirected the PC, saturating at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= '0;
        end else if (issue_hs && pc_load && (taken_cnt != 16'hFFFF)) begin
            taken_cnt <= taken_cnt + 16'd1;
        end
    end
`endif

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a memory responder pushes the expected
// {instr, pc} into a scoreboard when it acks; each test pops on retire.
module tb_pc_fetch;
    import cpu_pkg::*;

    localparam int             AW = DEFAULT_ADDR_W;
    localparam int             IW = DEFAULT_INSTR_W;
    localparam logic [AW-1:0]  RV = AW'(DEFAULT_RESET_VEC);

    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } exp_t;

    typedef struct {
        bit            timeout;
        logic [AW-1:0] addr;
        int            req_stable;
        logic          valid_after_ack;
        int            stall_ok;
        exp_t          got;
        logic          req_after;
        int            start_cyc;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pc_load = 1'b0;
    logic          pc_inc = 1'b0;
    logic [AW-1:0] a_val = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic          instr_valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;
`ifdef PC_PERF_CNT_EN
    logic [15:0]   taken_cnt;
    logic [15:0]   model_taken = '0;
`endif

    int            errors = 0;
    int            checks = 0;
    int            cycles = 0;
    logic [AW-1:0] model_pc = RV;
    exp_t          sb[$];

    pc_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_load     (pc_load),
        .pc_inc      (pc_inc),
        .a_val       (a_val),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
`ifdef PC_PERF_CNT_EN
        ,
        .taken_cnt   (taken_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycles <= cycles + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        logic [IW-1:0] w;
        w = {1'b0, a};
        return (w * 16'd7) ^ 16'h5A3C;
    endfunction

    function automatic bit sb_pop(output exp_t e);
        e.instr = '0;
        e.pc    = '0;
        if (sb.size() == 0) return 1'b0;
        e = sb.pop_front();
        return 1'b1;
    endfunction

    // One full instruction: wait for req, ack after ack_dly cycles, hold
    // ready low for stall cycles (scribbling the ignored jump inputs), retire.
    task automatic fetch_one(input int ack_dly, input int stall, input logic ld,
                             input logic inc, input logic [AW-1:0] av, output res_t r);
        int   n;
        exp_t snap;
        r.timeout = 1'b0; r.addr = '0; r.req_stable = 0; r.valid_after_ack = 1'b0;
        r.stall_ok = 0; r.got.instr = '0; r.got.pc = '0; r.req_after = 1'b0; r.start_cyc = 0;
        n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: imem_req=%b after %0d cycles, required 1", imem_req, n);
            r.timeout = 1'b1;
            return;
        end
        r.addr      = imem_addr;
        r.start_cyc = cycles;
        for (int i = 0; i < ack_dly; i++) begin
            if (imem_req === 1'b1 && imem_addr === r.addr) r.req_stable++;
            pc_load = 1'($urandom); pc_inc = 1'($urandom); a_val = AW'($urandom);
            @(negedge clk);
        end
        if (imem_req === 1'b1 && imem_addr === r.addr) r.req_stable++;
        pc_load = 1'b0; pc_inc = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        sb.push_back('{instr: mem_word(model_pc), pc: model_pc});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = IW'($urandom);
        r.valid_after_ack = instr_valid;
        snap.instr = instr;
        snap.pc    = instr_pc;
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            pc_load = 1'($urandom); pc_inc = 1'($urandom); a_val = AW'($urandom);
            @(negedge clk);
            if (instr_valid === 1'b1 && imem_req === 1'b0 &&
                instr === snap.instr && instr_pc === snap.pc) r.stall_ok++;
        end
        pc_load = ld; pc_inc = inc; a_val = av; instr_ready = 1'b1;
        r.got.instr = instr;
        r.got.pc    = instr_pc;
        @(negedge clk);
        if (ld) model_pc = av;
        else if (inc) model_pc = model_pc + 1'b1;
`ifdef PC_PERF_CNT_EN
        if (ld && model_taken != 16'hFFFF) model_taken = model_taken + 16'd1;
`endif
        instr_ready = 1'b0; pc_load = 1'b0; pc_inc = 1'b0; a_val = AW'($urandom);
        r.req_after = imem_req;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        imem_ack = 1'b0; instr_ready = 1'b0; pc_load = 1'b0; pc_inc = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_pc = RV;
        sb.delete();
`ifdef PC_PERF_CNT_EN
        model_taken = '0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== '0) begin errors++; $display("FAIL rst_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== RV) begin errors++; $display("FAIL rst_instr_pc: got %h want %h", instr_pc, RV); end
        checks++; if (imem_addr !== RV) begin errors++; $display("FAIL rst_addr: got %h want %h", imem_addr, RV); end
`ifdef PC_PERF_CNT_EN
        checks++; if (taken_cnt !== 16'd0) begin errors++; $display("FAIL rst_taken: got %0d want 0", taken_cnt); end
`endif
        rst_n = 1'b1;
        model_pc = RV;
        sb.delete();
    endtask

    task automatic test_sequential();
        res_t r;
        exp_t e;
        int   first_cyc;
        for (int i = 0; i < 4; i++) begin
            fetch_one(0, 0, 1'b0, 1'b1, '0, r);
            if (i == 0) first_cyc = r.start_cyc;
            checks++; if (r.addr !== AW'(i)) begin errors++; $display("FAIL seq_addr%0d: got %h want %h", i, r.addr, AW'(i)); end
            checks++; if (!sb_pop(e) || r.got.instr !== e.instr || r.got.pc !== e.pc) begin
                errors++; $display("FAIL seq_instr%0d: got %h@%h want %h@%h", i, r.got.instr, r.got.pc, e.instr, e.pc); end
            checks++; if (r.valid_after_ack !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b want 1", i, r.valid_after_ack); end
            checks++; if (r.req_after !== 1'b1) begin errors++; $display("FAIL seq_req_after%0d: got %b want 1", i, r.req_after); end
            if (i == 3) begin
                checks++; if (r.start_cyc - first_cyc !== 6) begin
                    errors++; $display("FAIL seq_throughput: got %0d cycles want 6", r.start_cyc - first_cyc); end
            end
        end
    endtask

    task automatic test_delayed_ack();
        res_t r;
        exp_t e;
        fetch_one(0, 0, 1'b1, 1'b0, AW'(5), r);
        void'(sb_pop(e));
        fetch_one(3, 0, 1'b0, 1'b1, '0, r);
        checks++; if (r.addr !== AW'(5)) begin errors++; $display("FAIL dly_addr: got %h want 5", r.addr); end
        checks++; if (r.req_stable !== 4) begin errors++; $display("FAIL dly_req_stable: got %0d want 4", r.req_stable); end
        checks++; if (r.valid_after_ack !== 1'b1) begin errors++; $display("FAIL dly_valid: got %b want 1", r.valid_after_ack); end
        checks++; if (!sb_pop(e) || r.got.instr !== e.instr || r.got.pc !== AW'(5)) begin
            errors++; $display("FAIL dly_instr: got %h@%h want %h@%h", r.got.instr, r.got.pc, e.instr, AW'(5)); end
    endtask

    task automatic test_load_priority();
        res_t r;
        exp_t e;
        fetch_one(0, 0, 1'b1, 1'b1, AW'(16'h0123), r);
        void'(sb_pop(e));
        fetch_one(0, 0, 1'b0, 1'b1, '0, r);
        checks++; if (r.addr !== AW'(16'h0123)) begin errors++; $display("FAIL prio_addr: got %h want 0123", r.addr); end
        checks++; if (!sb_pop(e) || r.got.instr !== e.instr || r.got.pc !== e.pc) begin
            errors++; $display("FAIL prio_instr: got %h@%h want %h@%h", r.got.instr, r.got.pc, e.instr, e.pc); end
    endtask

    task automatic test_wrap();
        res_t r;
        exp_t e;
        fetch_one(0, 0, 1'b1, 1'b0, AW'(16'h7FFF), r);
        void'(sb_pop(e));
        fetch_one(0, 0, 1'b0, 1'b1, '0, r);
        checks++; if (r.addr !== AW'(16'h7FFF)) begin errors++; $display("FAIL wrap_top: got %h want 7fff", r.addr); end
        void'(sb_pop(e));
        fetch_one(0, 0, 1'b0, 1'b1, '0, r);
        checks++; if (r.addr !== '0) begin errors++; $display("FAIL wrap_zero: got %h want 0000", r.addr); end
        checks++; if (!sb_pop(e) || r.got.instr !== e.instr || r.got.pc !== '0) begin
            errors++; $display("FAIL wrap_instr: got %h@%h want %h@0000", r.got.instr, r.got.pc, e.instr); end
    endtask

    task automatic test_stall();
        res_t          r;
        exp_t          e;
        logic [AW-1:0] base;
        base = model_pc;
        fetch_one(0, 5, 1'b0, 1'b1, '0, r);
        checks++; if (r.stall_ok !== 5) begin errors++; $display("FAIL stall_hold: got %0d stable cycles want 5", r.stall_ok); end
        checks++; if (!sb_pop(e) || r.got.instr !== e.instr || r.got.pc !== base) begin
            errors++; $display("FAIL stall_instr: got %h@%h want %h@%h", r.got.instr, r.got.pc, e.instr, base); end
        fetch_one(0, 0, 1'b0, 1'b0, '0, r);
        checks++; if (r.addr !== base + 1'b1) begin errors++; $display("FAIL stall_next: got %h want %h", r.addr, base + 1'b1); end
        void'(sb_pop(e));
        fetch_one(0, 0, 1'b0, 1'b1, '0, r);
        checks++; if (r.addr !== base + 1'b1) begin errors++; $display("FAIL hold_refetch: got %h want %h", r.addr, base + 1'b1); end
        void'(sb_pop(e));
    endtask

    task automatic test_reset_mid_fetch();
        res_t r;
        exp_t e;
        fetch_one(0, 0, 1'b1, 1'b0, AW'(9), r);
        void'(sb_pop(e));
        checks++; if (imem_req !== 1'b1 || imem_addr !== AW'(9)) begin
            errors++; $display("FAIL mid_pending: got req=%b addr=%h want req=1 addr=0009", imem_req, imem_addr); end
        #2;
        rst_n = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 16'hDEAD;
        #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL mid_drop: got req=%b valid=%b want 0/0", imem_req, instr_valid); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (instr_valid !== 1'b0 || instr !== '0) begin
            errors++; $display("FAIL mid_ack_ignored: got valid=%b instr=%h want 0/0000", instr_valid, instr); end
        imem_ack = 1'b0;
        rst_n = 1'b1;
        model_pc = RV;
        sb.delete();
        fetch_one(0, 0, 1'b0, 1'b1, '0, r);
        checks++; if (r.addr !== RV) begin errors++; $display("FAIL mid_restart: got %h want %h", r.addr, RV); end
        checks++; if (!sb_pop(e) || r.got.instr !== e.instr || r.got.pc !== RV) begin
            errors++; $display("FAIL mid_instr: got %h@%h want %h@%h", r.got.instr, r.got.pc, e.instr, RV); end
    endtask

`ifdef PC_PERF_CNT_EN
    task automatic test_perf_cnt();
        res_t r;
        exp_t e;
        apply_reset();
        fetch_one(0, 0, 1'b1, 1'b0, AW'(16'h0010), r); void'(sb_pop(e));
        fetch_one(0, 0, 1'b0, 1'b1, '0, r);            void'(sb_pop(e));
        fetch_one(0, 0, 1'b1, 1'b1, AW'(16'h0020), r); void'(sb_pop(e));
        fetch_one(0, 0, 1'b0, 1'b1, '0, r);            void'(sb_pop(e));
        fetch_one(0, 0, 1'b1, 1'b0, AW'(16'h0030), r); void'(sb_pop(e));
        checks++; if (taken_cnt !== 16'd3) begin errors++; $display("FAIL perf_taken: got %0d want 3", taken_cnt); end
        checks++; if (taken_cnt !== model_taken) begin errors++; $display("FAIL perf_model: got %0d want %0d", taken_cnt, model_taken); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_delayed_ack();
        test_load_priority();
        test_wrap();
        test_stall();
        test_reset_mid_fetch();
`ifdef PC_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_fetch

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program counter and instruction-fetch stage of the CPU.
- Sits directly downstream of the jump controller and consumes its pc_load/pc_inc decision for the retiring instruction.
- Holds the PC and fetches one instruction at a time from instruction memory over a req/ack handshake.
- Presents each instruction to decode/execute over a valid/ready handshake; non-speculative, at most one instruction in flight.

Parameters:
- ADDR_W, 15, PC and instruction-address width.
- INSTR_W, 16, instruction word width.
- RESET_VEC, 0, PC value loaded on reset (ADDR_W bits).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_load  in  1  from jump ctrl: load a_val as next PC; sampled only on the issue handshake
- pc_inc  in  1  from jump ctrl: next PC = PC+1; sampled only on the issue handshake
- a_val  in  ADDR_W  jump target (A register low bits)
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address (= PC)
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  INSTR_W  instruction data, valid with imem_ack
- instr_valid  out  1  instruction available to execute
- instr  out  INSTR_W  captured instruction
- instr_pc  out  ADDR_W  address of instr
- instr_ready  in  1  execute stage accepts instr (retire)

Behaviour:
- Reset (asynchronous, immediate, any state including mid-fetch):
  - PC = RESET_VEC, state = FETCH.
  - imem_req = 0, instr_valid = 0, instr = 0, instr_pc = RESET_VEC.
  - An outstanding memory transaction is abandoned; any ack arriving during reset is ignored.
- FSM, states FETCH and ISSUE (encoding in package):
  - FETCH:
    - imem_req = 1 and imem_addr = PC, both held stable until imem_ack.
    - On imem_ack: capture instr = imem_rdata and instr_pc = PC; next state ISSUE.
    - Zero-wait (ack in the same cycle as req) is legal; ack may also be delayed indefinitely.
  - ISSUE:
    - imem_req = 0, instr_valid = 1; instr and instr_pc held stable until instr_valid && instr_ready.
    - On handshake, update PC and go to FETCH:
      - pc_load = 1: PC = a_val. Load wins if pc_inc is also 1.
      - else pc_inc = 1: PC = PC+1, modulo 2^ADDR_W (0x7FFF -> 0x0000).
      - else: PC unchanged; the same address is refetched.
- Timing:
  - Issue handshake to next imem_req: exactly 1 cycle.
  - imem_ack to instr_valid: 1 cycle.
  - Best-case throughput: one instruction per 2 cycles.
- pc_load, pc_inc and a_val are ignored outside the issue handshake cycle.
- imem_ack outside FETCH is ignored.
- No combinational path from imem_ack or instr_ready to any output.

Optional Feature:
- Macro: PC_PERF_CNT_EN.
- Defined:
  - Adds output taken_cnt, 16 bits.
  - Increments on each issue handshake with pc_load = 1.
  - Saturates at 0xFFFF.
  - Reset value 0.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- cpu_pkg holds:
  - ADDR_W and INSTR_W defaults
  - RESET_VEC default
  - pc_fetch_state_e enum {FETCH, ISSUE}
  - HIGH/LOW constants
- One sub-module, pc_reg:
  - ADDR_W register with async reset to RESET_VEC.
  - Inputs: en, load, inc, d.
  - Implements load-priority and wraparound.
  - pc_fetch instantiates it and drives en from the issue handshake.

Test Plan:
- Reset then zero-wait ack, instr_ready = 1, pc_inc = 1 every retire -> imem_addr sequence 0,1,2,3; instr_valid on every other cycle.
- Ack delayed 3 cycles at addr 5 -> imem_req and imem_addr = 5 stable for 4 cycles; instr_valid 1 cycle after ack with instr_pc = 5.
- Handshake with pc_load = 1, pc_inc = 1, a_val = 0x0123 -> next imem_addr = 0x0123 (load priority).
- PC = 0x7FFF, pc_inc = 1 -> next imem_addr = 0x0000.
- instr_ready = 0 for 5 cycles -> instr and instr_pc stable, no imem_req; changing pc_load and a_val during the stall has no effect.
- rst_n asserted while imem_req is pending at addr 9 -> imem_req and instr_valid drop immediately; after release, fetch restarts at RESET_VEC.
- With PC_PERF_CNT_EN defined: 3 loads, 2 incs -> taken_cnt = 3.
